// File: rtl/karatsuba_seq_mult_if.sv
// Operand/product handshake bundle for the sequential Karatsuba multiplier.
// The master side stages operands and consumes products; the slave side is the multiplier.
interface karatsuba_seq_mult_if #(
  parameter int unsigned N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           in_signed;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_p;
  logic           busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, abort, out_ready,
    input  in_ready, out_valid, out_p, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, abort, out_ready,
    output in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/karatsuba_seq_mult.sv
// One-level Karatsuba multiplier that reuses one (N/2+1)-bit square multiplier over three cycles.
// Signed operands are handled as sign-magnitude: multiply magnitudes, negate the product at the end.
module karatsuba_seq_mult #(
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  karatsuba_seq_mult_if.slave  bus
);
  localparam int unsigned H  = N / 2;
  localparam int unsigned MW = H + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned W2 = 2 * N;

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_CMB, S_DONE
  } state_e;

  state_e          state_q;
  logic [H-1:0]    al_q, ah_q, bl_q, bh_q;
  logic            neg_q;
  logic [N-1:0]    z0_q, z2_q;
  logic [PW-1:0]   z1_q;
  logic [W2-1:0]   p_q;
  logic            in_ready_q, out_valid_q, busy_q;

  logic [N-1:0]    ua_d, ub_d;
  logic            neg_d;
  logic [MW-1:0]   mul_a, mul_b;
  logic [PW-1:0]   mul_p;
  logic [PW-1:0]   mid;
  logic [W2-1:0]   p_sum, p_d;

  // Operand magnitudes captured on input transfer.
  always_comb begin
    ua_d  = bus.in_a;
    ub_d  = bus.in_b;
    neg_d = bus.in_signed & (bus.in_a[N-1] ^ bus.in_b[N-1]);
    if (bus.in_signed && bus.in_a[N-1]) ua_d = -bus.in_a;
    if (bus.in_signed && bus.in_b[N-1]) ub_d = -bus.in_b;
  end

  // The shared multiplier, operand-muxed by state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_M0: begin
        mul_a = {1'b0, al_q};
        mul_b = {1'b0, bl_q};
      end
      S_M1: begin
        mul_a = {1'b0, ah_q};
        mul_b = {1'b0, bh_q};
      end
      S_M2: begin
        mul_a = MW'(al_q) + MW'(ah_q);
        mul_b = MW'(bl_q) + MW'(bh_q);
      end
      default: ;
    endcase
  end

  assign mul_p = PW'(mul_a) * PW'(mul_b);

  // Recombination; the middle term cannot underflow since z1 >= z0 + z2.
  always_comb begin
    mid   = z1_q - PW'(z0_q) - PW'(z2_q);
    p_sum = (W2'(z2_q) << N) + (W2'(mid) << H) + W2'(z0_q);
    p_d   = neg_q ? -p_sum : p_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      al_q        <= '0;
      ah_q        <= '0;
      bl_q        <= '0;
      bh_q        <= '0;
      neg_q       <= 1'b0;
      z0_q        <= '0;
      z2_q        <= '0;
      z1_q        <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            al_q       <= ua_d[H-1:0];
            ah_q       <= ua_d[N-1:H];
            bl_q       <= ub_d[H-1:0];
            bh_q       <= ub_d[N-1:H];
            neg_q      <= neg_d;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_M0;
          end
        end
        S_M0: begin
          z0_q    <= mul_p[N-1:0];
          state_q <= S_M1;
        end
        S_M1: begin
          z2_q    <= mul_p[N-1:0];
          state_q <= S_M2;
        end
        S_M2: begin
          z1_q    <= mul_p;
          state_q <= S_CMB;
        end
        S_CMB: begin
          p_q         <= p_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Cancel overrides whatever the active state decided.
      if (bus.abort && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
        busy_q      <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = p_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_karatsuba_seq_mult.sv
// Scoreboard bench for karatsuba_seq_mult: directed scenarios at N=32 and random runs at N=32/16/8.
module tb_karatsuba_seq_mult;
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  karatsuba_seq_mult_if #(.N(32)) if32 ();
  karatsuba_seq_mult_if #(.N(16)) if16 ();
  karatsuba_seq_mult_if #(.N(8))  if8  ();

  karatsuba_seq_mult #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  karatsuba_seq_mult #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  karatsuba_seq_mult #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic        iv [3];
  logic        sg [3];
  logic        ab [3];
  logic        ordy [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [63:0] po [3];

  assign if32.in_valid  = iv[0];
  assign if32.in_signed = sg[0];
  assign if32.abort     = ab[0];
  assign if32.out_ready = ordy[0];
  assign if32.in_a      = av[0];
  assign if32.in_b      = bv[0];
  assign if16.in_valid  = iv[1];
  assign if16.in_signed = sg[1];
  assign if16.abort     = ab[1];
  assign if16.out_ready = ordy[1];
  assign if16.in_a      = av[1][15:0];
  assign if16.in_b      = bv[1][15:0];
  assign if8.in_valid   = iv[2];
  assign if8.in_signed  = sg[2];
  assign if8.abort      = ab[2];
  assign if8.out_ready  = ordy[2];
  assign if8.in_a       = av[2][7:0];
  assign if8.in_b       = bv[2][7:0];

  assign ir[0] = if32.in_ready;
  assign ov[0] = if32.out_valid;
  assign bz[0] = if32.busy;
  assign po[0] = if32.out_p;
  assign ir[1] = if16.in_ready;
  assign ov[1] = if16.out_valid;
  assign bz[1] = if16.busy;
  assign po[1] = 64'(if16.out_p);
  assign ir[2] = if8.in_ready;
  assign ov[2] = if8.out_valid;
  assign bz[2] = if8.busy;
  assign po[2] = 64'(if8.out_p);

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q [$];

  // Reference: sign/zero-extend to 64 bits, multiply, keep the low 2w bits.
  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s, int w);
    logic [63:0] m, ea, eb, pr;
    m  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    ea = {32'b0, a} & m;
    eb = {32'b0, b} & m;
    if (s && ea[w-1]) ea = ea | ~m;
    if (s && eb[w-1]) eb = eb | ~m;
    pr = ea * eb;
    if (w != 32) pr = pr & ((64'd1 << (2 * w)) - 64'd1);
    return pr;
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] m, one;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    one = 32'd1;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return one;
      2:       return m;
      3:       return one << (w - 1);
      4:       return (one << (w - 1)) | one;
      default: return $urandom() & m;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; sg[k] = 1'b0; ab[k] = 1'b0; ordy[k] = 1'b1;
      av[k] = 32'd0; bv[k] = 32'd0;
    end
  endtask

  // Present one operand pair on instance 0, push its expected product on acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] exp, output int ok);
    iv[0] = 1'b1; av[0] = a; bv[0] = b; sg[0] = s;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (ir[0]) begin ok = 1; break; end
      tick();
    end
    if (ok != 0) sb_q.push_back(exp);
    tick();
    iv[0] = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ov[0] && lat < 40) begin
      tick();
      lat++;
    end
    if (!ov[0]) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b0 || ov[k] !== 1'b0 || bz[k] !== 1'b0 || po[k] !== 64'd0) begin
        bad++;
        $display("FAIL reset_vals[%0d]: got ir=%b ov=%b busy=%b p=%h want 0 0 0 0", k, ir[k], ov[k], bz[k], po[k]);
      end
    end
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_ready[%0d]: got %b want 1", k, ir[k]);
      end
    end
  endtask

  task automatic test_unsigned();
    int ok, lat;
    logic [63:0] e;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, ok);
    total++;
    if (bz[0] !== 1'b1 || ir[0] !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_accept: got busy=%b ir=%b want 1 0", bz[0], ir[0]);
    end
    wait_valid(lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL unsigned_latency: got %0d want 4", lat); end
    e = sb_q.pop_front();
    total++;
    if (po[0] !== e) begin bad++; $display("FAIL unsigned_max: got %h want %h", po[0], e); end
    tick();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_post: got ov=%b ir=%b busy=%b want 0 1 0", ov[0], ir[0], bz[0]);
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        ts [3];
    logic [63:0] te [3];
    int ok, lat;
    logic [63:0] e;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd5;          ts[0] = 1'b1; te[0] = 64'hFFFF_FFFF_FFFF_FFFB;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;  ts[1] = 1'b1; te[1] = 64'h4000_0000_0000_0000;
    ta[2] = 32'h8000_0000; tb[2] = 32'd2;          ts[2] = 1'b0; te[2] = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb[i], ts[i], te[i], ok);
      wait_valid(lat);
      e = sb_q.pop_front();
      total++;
      if (lat != 4 || po[0] !== e) begin
        bad++;
        $display("FAIL signed_case%0d: got p=%h lat=%0d want p=%h lat=4", i, po[0], lat, e);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int ok, lat, stable;
    logic [63:0] e;
    ordy[0] = 1'b0;
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, model(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32), ok);
    wait_valid(lat);
    e = sb_q.pop_front();
    total++;
    if (po[0] !== e) begin bad++; $display("FAIL bp_value: got %h want %h", po[0], e); end
    iv[0] = 1'b1; av[0] = 32'd3; bv[0] = 32'd3;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov[0] !== 1'b1 || po[0] !== e || ir[0] !== 1'b0) stable = 0;
    end
    total++;
    if (stable != 1) begin
      bad++;
      $display("FAIL bp_hold: got ov=%b ir=%b p=%h want 1 0 %h", ov[0], ir[0], po[0], e);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got ov=%b ir=%b want 0 1", ov[0], ir[0]);
    end
    tick();
    total++;
    if (bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_extra: got busy=%b ov=%b want 0 0", bz[0], ov[0]);
    end
  endtask

  task automatic test_abort();
    int ok, lat, rose;
    logic [63:0] e;
    send(32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 64'h0, ok);
    tick();
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    sb_q.delete();
    total++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0 || ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got ir=%b busy=%b ov=%b want 1 0 0", ir[0], bz[0], ov[0]);
    end
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov[0] !== 1'b0) rose = 1;
    end
    total++;
    if (rose != 0) begin bad++; $display("FAIL abort_no_output: got out_valid rise want none"); end
    // Abort while idle must not block a simultaneous acceptance.
    ab[0] = 1'b1;
    iv[0] = 1'b1; av[0] = 32'd3; bv[0] = 32'd7; sg[0] = 1'b0;
    sb_q.push_back(64'd21);
    tick();
    iv[0] = 1'b0;
    ab[0] = 1'b0;
    wait_valid(lat);
    e = sb_q.pop_front();
    total++;
    if (lat != 4 || po[0] !== e) begin
      bad++;
      $display("FAIL abort_next_op: got p=%h lat=%0d want p=%h lat=4", po[0], lat, e);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int ok, lat;
    logic [63:0] e;
    send(32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 64'h0, ok);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    total++;
    if (ir[0] !== 1'b0 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || po[0] !== 64'd0) begin
      bad++;
      $display("FAIL midreset_vals: got ir=%b ov=%b busy=%b p=%h want 0 0 0 0", ir[0], ov[0], bz[0], po[0]);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_ready: got ir=%b ov=%b want 1 0", ir[0], ov[0]);
    end
    send(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, ok);
    wait_valid(lat);
    e = sb_q.pop_front();
    total++;
    if (lat != 4 || po[0] !== e) begin
      bad++;
      $display("FAIL midreset_next_op: got p=%h lat=%0d want p=%h lat=4", po[0], lat, e);
    end
    tick();
  endtask

  task automatic rand_run(input int k, input int w, input int nops);
    logic [63:0] q [$];
    logic [63:0] e;
    int sent, cyc, nbad;
    sent = 0; cyc = 0; nbad = 0;
    while ((sent < nops || q.size() != 0) && cyc < 20 * nops + 200) begin
      if (sent < nops) begin
        iv[k] = ($urandom_range(0, 3) != 0);
        av[k] = pick(w);
        bv[k] = pick(w);
        sg[k] = 1'($urandom_range(0, 1));
      end else begin
        iv[k] = 1'b0;
      end
      ordy[k] = ($urandom_range(0, 3) != 0);
      if (iv[k] && ir[k]) begin
        q.push_back(model(av[k], bv[k], sg[k], w));
        sent++;
      end
      if (ov[k] && ordy[k]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_n%0d_spurious: got out_valid with p=%h want no output", w, po[k]);
        end else begin
          e = q.pop_front();
          if (po[k] !== e) begin
            bad++;
            nbad++;
            if (nbad < 10) $display("FAIL rand_n%0d: got %h want %h", w, po[k], e);
          end
        end
      end
      tick();
      cyc++;
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    total++;
    if (sent != nops || q.size() != 0) begin
      bad++;
      $display("FAIL rand_n%0d_drain: got sent=%0d pending=%0d want sent=%0d pending=0", w, sent, q.size(), nops);
    end
  endtask

  task automatic test_random();
    fork
      rand_run(0, 32, 4000);
      rand_run(1, 16, 3000);
      rand_run(2, 8, 3000);
    join
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
